mod_updown_counter: RTL

Parametrised successor to the 8-bit binary counter: modulo-N counter with selectable up, down, ping-pong and hold modes, plus synchronous load and count enable. It provides a terminal-count pulse, a direction flag and a Gray-coded copy of the count. It is used as a generic timebase, address sequencer and pattern source in lab designs and benches.

---
 rtl/mod_updown_counter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// ----------------------------------------------------------------------------
// mod_updown_counter
//
// Modulo-MOD counter with up, down, ping-pong and hold modes, synchronous
// load (clamped to MOD-1) and count enable. Also gives a one-cycle
// terminal-count pulse, a direction flag and a Gray-coded copy of the count.
//
// Ports:
//   i_clk       clock, all state changes on the rising edge
//   i_rst       synchronous active-high reset
//   i_en        count enable (low = hold count and direction)
//   i_mode      00 up, 01 down, 10 ping-pong, 11 hold
//   i_load      synchronous load strobe (beats i_en, loses to i_rst)
//   i_load_val  value to load, clamped to MOD-1
//   o_cnt       registered count
//   o_gray      o_cnt ^ (o_cnt >> 1), combinational
//   o_dir       registered direction, 0 up / 1 down
//   o_tc        registered terminal-count pulse
// ----------------------------------------------------------------------------
module mod_updown_counter #(
    parameter int WIDTH = 8,
    parameter int MOD   = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_gray,
    output logic             o_dir,
    output logic             o_tc
);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    // Endpoint constants. MOD may equal 2**WIDTH, so the range check on the
    // load value is done one bit wider than the counter.
    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] MAX_M1_VAL = WIDTH'(MOD - 2);
    localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH+1)'(MOD);

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             tc_reg, tc_next;
    logic             load_in_range;

    assign load_in_range = ({1'b0, i_load_val} < MOD_EXT);

    always_comb begin
        cnt_next = cnt_reg;
        dir_next = dir_reg;
        tc_next  = 1'b0;
        if (i_load) begin
            // Load leaves the direction alone so ping-pong resumes its sweep.
            cnt_next = load_in_range ? i_load_val : MAX_VAL;
        end else if (i_en) begin
            case (i_mode)
                MODE_UP: begin
                    dir_next = 1'b0;
                    if (cnt_reg == MAX_VAL) begin
                        cnt_next = '0;
                        tc_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    dir_next = 1'b1;
                    if (cnt_reg == '0) begin
                        cnt_next = MAX_VAL;
                        tc_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - WIDTH'(1);
                    end
                end
                MODE_PING: begin
                    // Turning steps straight to the neighbour of the endpoint
                    // so no endpoint value is output twice in a row.
                    if (!dir_reg) begin
                        if (cnt_reg == MAX_VAL) begin
                            cnt_next = MAX_M1_VAL;
                            dir_next = 1'b1;
                            tc_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + WIDTH'(1);
                        end
                    end else begin
                        if (cnt_reg == '0) begin
                            cnt_next = WIDTH'(1);
                            dir_next = 1'b0;
                            tc_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_reg - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    // Mode 11: hold, defaults already apply.
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg <= '0;
            dir_reg <= 1'b0;
            tc_reg  <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            dir_reg <= dir_next;
            tc_reg  <= tc_next;
        end
    end

    assign o_cnt = cnt_reg;
    assign o_dir = dir_reg;
    assign o_tc  = tc_reg;

    // Gray code: each bit is the XOR of adjacent count bits, MSB passes through.
    assign o_gray[WIDTH-1] = cnt_reg[WIDTH-1];
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
        assign o_gray[gi] = cnt_reg[gi] ^ cnt_reg[gi+1];
    end

endmodule
